// File: rtl/noc_vc_link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_link_receiver
// Purpose  : Virtual-channel NoC link receive end. Holds one FIFO per VC and
//            checks packet framing on each VC, with sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module noc_vc_link_receiver #(
    parameter int VCHANNELS      = 3,
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int NOC_FLIT_WIDTH = NOC_DATA_WIDTH + NOC_TYPE_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NOC_FLIT_WIDTH-1:0]           link_flit_i,
    input  logic [VCHANNELS-1:0]                link_valid_i,
    output logic [VCHANNELS-1:0]                link_ready_o,
    output logic [NOC_FLIT_WIDTH*VCHANNELS-1:0] out_flit_o,
    output logic [VCHANNELS-1:0]                out_valid_o,
    input  logic [VCHANNELS-1:0]                out_ready_i,
    output logic [VCHANNELS-1:0]                err_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_full = CW'(FIFO_DEPTH);

    localparam logic [NOC_TYPE_WIDTH-1:0] c_payload = 2'b00;
    localparam logic [NOC_TYPE_WIDTH-1:0] c_header  = 2'b01;
    localparam logic [NOC_TYPE_WIDTH-1:0] c_last    = 2'b10;
    localparam logic [NOC_TYPE_WIDTH-1:0] c_single  = 2'b11;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_INPKT = 1'b1;

    logic                      w_onehot;
    logic                      w_multi;
    logic [NOC_TYPE_WIDTH-1:0] w_type;

    // Only a single-VC valid is a legal link transfer; anything wider is a collision
    assign w_onehot = (link_valid_i != '0) &&
                      ((link_valid_i & (link_valid_i - VCHANNELS'(1))) == '0);
    assign w_multi  = (link_valid_i != '0) && !w_onehot;
    assign w_type   = link_flit_i[NOC_FLIT_WIDTH-1 -: NOC_TYPE_WIDTH];

    generate
        for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
            logic [NOC_FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
            logic [PW-1:0]             r_wptr;
            logic [PW-1:0]             r_rptr;
            logic [CW-1:0]             r_count;
            logic [0:0]                r_state;
            logic [0:0]                w_state_nxt;
            logic                      w_frame_err;
            logic                      w_push;
            logic                      w_pop;

            assign link_ready_o[v] = ~rst & (r_count != c_full);
            assign out_valid_o[v]  = (r_count != '0);
            assign out_flit_o[(v+1)*NOC_FLIT_WIDTH-1 : v*NOC_FLIT_WIDTH] = r_mem[r_rptr];

            assign w_push = link_valid_i[v] & link_ready_o[v] & w_onehot;
            assign w_pop  = out_valid_o[v] & out_ready_i[v];

            always_comb begin
                w_state_nxt = r_state;
                w_frame_err = 1'b0;
                if (w_push) begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_type == c_header)
                                w_state_nxt = S_INPKT;
                            else if (w_type != c_single)
                                w_frame_err = 1'b1;
                        end
                        default: begin
                            if (w_type == c_last) begin
                                w_state_nxt = S_IDLE;
                            end else if (w_type == c_single) begin
                                w_state_nxt = S_IDLE;
                                w_frame_err = 1'b1;
                            end else if (w_type != c_payload) begin
                                w_frame_err = 1'b1;
                            end
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_state <= S_IDLE;
                    err_o[v] <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_push)
                        r_wptr <= r_wptr + PW'(1);
                    if (w_pop)
                        r_rptr <= r_rptr + PW'(1);
                    if (w_push && !w_pop)
                        r_count <= r_count + CW'(1);
                    else if (!w_push && w_pop)
                        r_count <= r_count - CW'(1);
                    if (w_frame_err || (w_multi && link_valid_i[v]))
                        err_o[v] <= 1'b1;
                end
            end

            // Storage carries no reset; stale entries are unreachable once count is 0
            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wptr] <= link_flit_i;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_vc_link_receiver
// Purpose  : Self-checking bench for noc_vc_link_receiver against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_vc_link_receiver;

    localparam int VC = 3;
    localparam int DW = 32;
    localparam int FW = 34;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FW-1:0]     link_flit = '0;
    logic [VC-1:0]     link_valid = '0;
    logic [VC-1:0]     link_ready;
    logic [FW*VC-1:0]  out_flit;
    logic [VC-1:0]     out_valid;
    logic [VC-1:0]     out_ready = '0;
    logic [VC-1:0]     err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [FW-1:0] mq [VC][$];
    bit            m_inpkt [VC];
    logic [VC-1:0] m_err;

    always #5 clk = ~clk;

    noc_vc_link_receiver #(
        .VCHANNELS(VC), .NOC_DATA_WIDTH(DW), .NOC_TYPE_WIDTH(2),
        .NOC_FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .link_flit_i(link_flit), .link_valid_i(link_valid), .link_ready_o(link_ready),
        .out_flit_o(out_flit), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .err_o(err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [DW-1:0] d);
        return {t, d};
    endfunction

    task automatic check_outputs();
        for (int v = 0; v < VC; v++) begin
            check_eq($sformatf("ready%0d", v), 64'(link_ready[v]), 64'(mq[v].size() != DEPTH));
            check_eq($sformatf("valid%0d", v), 64'(out_valid[v]), 64'(mq[v].size() != 0));
            if (mq[v].size() != 0)
                check_eq($sformatf("flit%0d", v), 64'(out_flit[v*FW +: FW]), 64'(mq[v][0]));
        end
        check_eq("err", 64'(err), 64'(m_err));
    endtask

    // Model: one transfer per cycle only when exactly one VC is valid; framing
    // follows the packet rules (HEADER opens, LAST closes, SINGLE is standalone).
    task automatic step(input logic [VC-1:0] v_in, input logic [FW-1:0] f, input logic [VC-1:0] r);
        logic [1:0] t;
        bit one;
        check_outputs();
        link_valid = v_in;
        link_flit  = f;
        out_ready  = r;
        one = ($countones(v_in) == 1);
        t = f[FW-1 -: 2];
        for (int v = 0; v < VC; v++) begin
            bit acc;
            acc = v_in[v] && one && (mq[v].size() < DEPTH);
            if (v_in[v] && !one) m_err[v] = 1'b1;
            if (r[v] && mq[v].size() > 0) void'(mq[v].pop_front());
            if (acc) begin
                mq[v].push_back(f);
                if (!m_inpkt[v]) begin
                    if (t == 2'b01) m_inpkt[v] = 1;
                    else if (t != 2'b11) m_err[v] = 1'b1;
                end else begin
                    if (t == 2'b10) m_inpkt[v] = 0;
                    else if (t == 2'b11) begin m_inpkt[v] = 0; m_err[v] = 1'b1; end
                    else if (t == 2'b01) m_err[v] = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        link_valid = '0;
        out_ready  = '0;
    endtask

    task automatic do_reset();
        link_valid = '0;
        out_ready  = '0;
        rst = 1'b1;
        #1;
        check_eq("rst_ready", 64'(link_ready), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        for (int v = 0; v < VC; v++) begin
            mq[v].delete();
            m_inpkt[v] = 0;
        end
        m_err = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(link_ready), 64'h7);
    endtask

    function automatic logic [VC-1:0] rand_valid();
        int r;
        logic [VC-1:0] m [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
        r = $urandom_range(0, 19);
        if (r < 5) return '0;
        if (r < 19) return VC'(1 << $urandom_range(0, VC-1));
        return m[$urandom_range(0, 3)];
    endfunction

    initial begin
        @(negedge clk);
        do_reset();

        // VC1 packet with consumer stalled
        step(3'b010, mk(2'b01, 32'h5), 3'b000);
        step(3'b010, mk(2'b00, 32'hAAAA), 3'b000);
        step(3'b010, mk(2'b10, 32'hBBBB), 3'b000);
        check_eq("tp1_valid", 64'(out_valid), 64'h2);
        check_eq("tp1_flit", 64'(out_flit[2*FW-1:FW]), 64'h100000005);
        check_eq("tp1_err", 64'(err), 64'h0);
        repeat (3) step('0, '0, 3'b010);

        // VC0 fills, fifth flit refused, one pop frees a slot
        for (int i = 0; i < 4; i++) step(3'b001, mk(2'b11, 32'(i + 16)), 3'b000);
        check_eq("tp2_full_ready", 64'(link_ready[0]), 64'h0);
        step(3'b001, mk(2'b11, 32'h99), 3'b000);
        step('0, '0, 3'b001);
        check_eq("tp2_ready_back", 64'(link_ready[0]), 64'h1);
        repeat (3) step('0, '0, 3'b001);

        // Full VC2: pop concurrent with valid must not write
        for (int i = 0; i < 4; i++) step(3'b100, mk(2'b11, 32'(i + 32)), 3'b000);
        step(3'b100, mk(2'b11, 32'h77), 3'b100);
        check_eq("tp3_head", 64'(out_flit[3*FW-1:2*FW]), 64'(mk(2'b11, 32'd33)));
        repeat (4) step('0, '0, 3'b100);

        // Collision on VC0+VC1
        step(3'b011, mk(2'b11, 32'h1), 3'b000);
        check_eq("tp4_err", 64'(err), 64'h3);
        check_eq("tp4_valid", 64'(out_valid), 64'h0);

        // Framing errors
        do_reset();
        step(3'b001, mk(2'b00, 32'h123), 3'b000);
        check_eq("tp5_err0", 64'(err[0]), 64'h1);
        step(3'b100, mk(2'b01, 32'h1), 3'b000);
        step(3'b100, mk(2'b01, 32'h2), 3'b000);
        check_eq("tp5_err2", 64'(err[2]), 64'h1);
        repeat (3) step('0, '0, 3'b101);

        // Nine flits through VC0 with random stalls
        do_reset();
        begin
            int sent = 0;
            int budget = 200;
            while ((sent < 9 || mq[0].size() != 0) && budget > 0) begin
                logic [VC-1:0] vv;
                vv = (sent < 9 && mq[0].size() < DEPTH) ? 3'b001 : 3'b000;
                if (vv[0]) sent++;
                step(vv, mk((sent == 1) ? 2'b01 : (sent == 9) ? 2'b10 : 2'b00, $urandom()),
                     VC'($urandom_range(0, 1)));
                budget--;
            end
            check_eq("tp6_budget", 64'(budget > 0), 64'h1);
        end
        check_eq("tp6_err", 64'(err), 64'h0);

        // Randomised traffic with periodic mid-packet resets
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 150) do_reset();
            step(rand_valid(), mk(2'($urandom_range(0, 3)), $urandom()), VC'($urandom()));
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
